// File: rtl/fft_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft_seq_ctrl
//
// Sequencer for an in-place radix-2 decimation-in-time FFT datapath.
// A start pulse begins a LOAD phase: the next 2**N_LOG2 input samples are
// written to data RAM port A at bit-reversed addresses. A CALC phase follows.
// It runs N_LOG2 stages of N/2 butterflies. Each butterfly performs these
// steps in order:
//   - read its operand pair
//   - pulse bf_start together with the twiddle index
//   - write both results back to the same addresses.
// When the last write-back is issued the sequencer enters DONE. In DONE it
// raises fft_finish and returns RAM read port A to the external readout
// address.
//
// Parameters
//   N_LOG2  log2 of the transform length (>= 2)
//   BF_LAT  butterfly latency from bf_start to result valid (>= 1)
//
// Optional feature macro
//   FFT_CTRL_IFFT_EN  when defined, ifft_mode is latched with an accepted
//                     start and drives tw_conj for the whole CALC phase;
//                     when undefined, ifft_mode is ignored and tw_conj is 0.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   initial_en   1-cycle start pulse (ignored while busy)
//   read_addr    readout address, routed to ram_raddr_a outside CALC
//   ifft_mode    inverse-transform request, sampled with initial_en
//   ram_we       RAM write enable
//   ram_wsel     0: port A <- external data, 1: ports A/B <- butterfly
//   ram_waddr_a  write address port A
//   ram_waddr_b  write address port B
//   ram_raddr_a  read address port A
//   ram_raddr_b  read address port B
//   bf_start     butterfly operand-capture pulse
//   tw_idx       twiddle ROM index, valid with bf_start
//   tw_conj      conjugate twiddle during CALC
//   busy         high in LOAD and CALC
//   fft_finish   high in DONE
// ---------------------------------------------------------------------------
module fft_seq_ctrl #(
    parameter int N_LOG2 = 3,
    parameter int BF_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              initial_en,
    input  logic [N_LOG2-1:0] read_addr,
    input  logic              ifft_mode,
    output logic              ram_we,
    output logic              ram_wsel,
    output logic [N_LOG2-1:0] ram_waddr_a,
    output logic [N_LOG2-1:0] ram_waddr_b,
    output logic [N_LOG2-1:0] ram_raddr_a,
    output logic [N_LOG2-1:0] ram_raddr_b,
    output logic              bf_start,
    output logic [N_LOG2-2:0] tw_idx,
    output logic              tw_conj,
    output logic              busy,
    output logic              fft_finish
);

    localparam int K_W  = N_LOG2 - 1;
    localparam int S_W  = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int PH_W = $clog2(BF_LAT + 2);

    localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};
    localparam logic [K_W-1:0]    K_LAST   = {K_W{1'b1}};
    localparam logic [S_W-1:0]    S_LAST   = S_W'(N_LOG2 - 1);
    localparam logic [PH_W-1:0]   PH_BF    = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(BF_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              start_acc;

    logic [N_LOG2-1:0] k_ext, span, pos, addr_a, addr_b;
    logic [K_W-1:0]    tw_val;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    // A start is only taken when not busy.
    assign start_acc = initial_en && ((state_q == IDLE) || (state_q == DONE));

`ifdef FFT_CTRL_IFFT_EN
    logic conj_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conj_q <= 1'b0;
        end else if (start_acc) begin
            conj_q <= ifft_mode;
        end
    end
`else
    logic conj_q;
    logic unused_ifft_mode;
    assign conj_q           = 1'b0;
    assign unused_ifft_mode = ifft_mode;
`endif

    // Butterfly k of stage s pairs addr_a with addr_a + span. Here addr_a is
    // k with a zero inserted at bit position s. The twiddle index is the
    // position inside the group, scaled up to the full-length ROM.
    always_comb begin
        k_ext  = {1'b0, k_q};
        span   = N_LOG2'(1) << s_q;
        pos    = k_ext & (span - 1'b1);
        addr_a = (((k_ext >> s_q) << s_q) << 1) | pos;
        addr_b = addr_a + span;
        tw_val = pos[K_W-1:0] << (S_LAST - s_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        k_d         = k_q;
        ph_d        = ph_q;
        ram_we      = 1'b0;
        ram_wsel    = 1'b0;
        ram_waddr_a = '0;
        ram_waddr_b = '0;
        ram_raddr_a = read_addr;
        ram_raddr_b = '0;
        bf_start    = 1'b0;
        tw_idx      = '0;
        tw_conj     = 1'b0;
        busy        = 1'b0;
        fft_finish  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end

            LOAD: begin
                busy        = 1'b1;
                ram_we      = 1'b1;
                ram_waddr_a = bitrev(cnt_q);
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CALC;
                end
            end

            CALC: begin
                busy        = 1'b1;
                ram_raddr_a = addr_a;
                ram_raddr_b = addr_b;
                tw_conj     = conj_q;
                if (ph_q == PH_BF) begin
                    bf_start = 1'b1;
                    tw_idx   = tw_val;
                end
                if (ph_q == PH_LAST) begin
                    // Write-back phase; also the point where counters advance.
                    ram_we      = 1'b1;
                    ram_wsel    = 1'b1;
                    ram_waddr_a = addr_a;
                    ram_waddr_b = addr_b;
                    ph_d        = '0;
                    k_d         = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        s_d = s_q + 1'b1;
                        if (s_q == S_LAST) begin
                            s_d     = '0;
                            state_d = DONE;
                        end
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            DONE: begin
                fft_finish = 1'b1;
                if (start_acc) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
